// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_ls_pipe load/store memory: size encodings,
// the response record and the lane mask / store align / load extract helpers.
package dmem_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic              valid;
        logic              fault;
        logic [WORD_W-1:0] rdata;
    } rsp_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lane;
            SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Right-aligned store data is replicated so every lane the mask selects sees it.
    function automatic logic [WORD_W-1:0] store_align(input logic [1:0] size,
                                                      input logic [WORD_W-1:0] wdata);
        case (size)
            SZ_BYTE: store_align = {4{wdata[7:0]}};
            SZ_HALF: store_align = {2{wdata[15:0]}};
            default: store_align = wdata;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] load_extract(input logic [WORD_W-1:0] word,
                                                       input logic [1:0]        size,
                                                       input logic [1:0]        lane,
                                                       input logic              is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extract = {{24{~is_unsigned & b[7]}}, b};
            SZ_HALF: load_extract = {{16{~is_unsigned & h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Fixed-depth response shift pipeline of {valid, fault, rdata}; rst flushes
// every stage so in-flight responses are dropped.
module dmem_rsp_pipe
    import dmem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_fault,
    input  logic [WORD_W-1:0] i_rdata,
    output logic              o_valid,
    output logic              o_fault,
    output logic [WORD_W-1:0] o_rdata
);

    rsp_t r_stage [LAT];

    // NOTE: sequential state uses <= so every stage samples its predecessor's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= '{valid: i_valid, fault: i_fault, rdata: i_rdata};
            for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_valid = r_stage[LAT-1].valid;
    assign o_fault = r_stage[LAT-1].fault;
    assign o_rdata = r_stage[LAT-1].rdata;

endmodule

// File: rtl/dmem_ls_pipe.sv
// Byte-addressed load/store data memory with a fixed-latency response pipeline.
// Define DMEM_STATS_EN to add the stat_loads/stat_stores/stat_faults counters.
module dmem_ls_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = 256,
    parameter int READ_LAT   = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_faults
`endif
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              r_ready;
    logic              w_accept;
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_lane;
    logic [MEM_AW-1:0] w_mem_idx;
    logic              w_in_range;
    logic              w_misalign;
    logic              w_fault;
    logic              w_wr_en;
    logic [3:0]        w_wr_mask;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W-1:0] w_words [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ready <= 1'b0;
        else     r_ready <= 1'b1;
    end

    assign req_ready = r_ready;
    assign w_accept  = req_valid & r_ready;
    assign w_idx     = req_addr[ADDR_W-1:2];
    assign w_lane    = req_addr[1:0];
    assign w_mem_idx = w_idx[MEM_AW-1:0];

    assign w_in_range = 32'(w_idx) < 32'(DEPTH);
    assign w_misalign = ((req_size == SZ_HALF) && w_lane[0]) ||
                        ((req_size == SZ_WORD) && (w_lane != 2'b00));
    assign w_fault    = (req_size == 2'b11) | w_misalign | ~w_in_range;

    assign w_wr_en   = w_accept & req_write & ~w_fault;
    assign w_wr_mask = lane_mask(req_size, w_lane);
    assign w_wr_data = store_align(req_size, req_wdata);

    // Array words carry their time-zero value as a declaration initialiser.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [DATA_W-1:0] r_word = (INIT_INDEX != 0) ? DATA_W'(g) : '0;

        // NOTE: no reset on array storage; rst must leave memory contents intact.
        always_ff @(posedge clk) begin
            if (w_wr_en && (w_mem_idx == MEM_AW'(g))) begin
                for (int l = 0; l < 4; l++) begin
                    if (w_wr_mask[l]) r_word[8*l +: 8] <= w_wr_data[8*l +: 8];
                end
            end
        end

        assign w_words[g] = r_word;
    end

    assign w_rd_word = w_in_range ? w_words[w_mem_idx] : '0;
    assign w_ld_data = (w_accept && !req_write && !w_fault)
                     ? load_extract(w_rd_word, req_size, w_lane, req_unsigned) : '0;

    dmem_rsp_pipe #(
        .LAT(READ_LAT)
    ) u_rsp_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_valid(w_accept),
        .i_fault(w_fault),
        .i_rdata(w_ld_data),
        .o_valid(rsp_valid),
        .o_fault(rsp_fault),
        .o_rdata(rsp_rdata)
    );

`ifdef DMEM_STATS_EN
    logic [31:0] r_stat_loads;
    logic [31:0] r_stat_stores;
    logic [31:0] r_stat_faults;

    // Saturating counters bumped on the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_loads  <= '0;
            r_stat_stores <= '0;
            r_stat_faults <= '0;
        end else if (w_accept) begin
            if (w_fault) begin
                if (r_stat_faults != '1) r_stat_faults <= r_stat_faults + 32'd1;
            end else if (req_write) begin
                if (r_stat_stores != '1) r_stat_stores <= r_stat_stores + 32'd1;
            end else begin
                if (r_stat_loads != '1) r_stat_loads <= r_stat_loads + 32'd1;
            end
        end
    end

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_faults = r_stat_faults;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dmem_ls_pipe.sv
// Scoreboard bench for dmem_ls_pipe: instance A (READ_LAT=1) and B (READ_LAT=3).
module tb_dmem_ls_pipe;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [15:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    req_t req_a = '0;
    req_t req_b = '0;
    logic        ready_a, valid_a, fault_a;
    logic        ready_b, valid_b, fault_b;
    logic [31:0] rdata_a, rdata_b;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_loads = 0, exp_stores = 0, exp_faults = 0;
    exp_t q_a[$];
    exp_t q_b[$];

`ifdef DMEM_STATS_EN
    logic [31:0] st_ld_a, st_st_a, st_ft_a, st_ld_b, st_st_b, st_ft_b;
`endif

    dmem_ls_pipe #(
        .DATA_W(32), .ADDR_W(16), .DEPTH(256), .READ_LAT(LAT_A), .INIT_INDEX(1)
    ) u_dut_a (
        .clk(clk), .rst(rst_a),
        .req_valid(req_a.valid), .req_ready(ready_a), .req_write(req_a.write),
        .req_size(req_a.size), .req_unsigned(req_a.uns), .req_addr(req_a.addr),
        .req_wdata(req_a.wdata),
        .rsp_valid(valid_a), .rsp_rdata(rdata_a), .rsp_fault(fault_a)
`ifdef DMEM_STATS_EN
        , .stat_loads(st_ld_a), .stat_stores(st_st_a), .stat_faults(st_ft_a)
`endif
    );

    dmem_ls_pipe #(
        .DATA_W(32), .ADDR_W(16), .DEPTH(256), .READ_LAT(LAT_B), .INIT_INDEX(1)
    ) u_dut_b (
        .clk(clk), .rst(rst_b),
        .req_valid(req_b.valid), .req_ready(ready_b), .req_write(req_b.write),
        .req_size(req_b.size), .req_unsigned(req_b.uns), .req_addr(req_b.addr),
        .req_wdata(req_b.wdata),
        .rsp_valid(valid_b), .rsp_rdata(rdata_b), .rsp_fault(fault_b)
`ifdef DMEM_STATS_EN
        , .stat_loads(st_ld_b), .stat_stores(st_st_b), .stat_faults(st_ft_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor side: pops the oldest expectation whenever a response pulse is seen.
    task automatic monitor(input bit sel, input logic v, input logic [31:0] d, input logic f);
        exp_t  e;
        string p;
        p = sel ? "b" : "a";
        if (!v) return;
        if ((sel ? q_b.size() : q_a.size()) == 0) begin
            check({p, "_unexpected_rsp"}, 32'd1, 32'd0);
            return;
        end
        e = sel ? q_b.pop_front() : q_a.pop_front();
        check({p, "_rdata"}, d, e.rdata);
        check({p, "_fault"}, {31'd0, f}, {31'd0, e.fault});
        check({p, "_latency_cycle"}, cyc, e.cyc);
    endtask

    always @(negedge clk) monitor(1'b0, valid_a, rdata_a, fault_a);
    always @(negedge clk) monitor(1'b1, valid_b, rdata_b, fault_b);

    // Stimulus side: drive one request and push its hand-computed response.
    task automatic issue(input bit sel, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_f, input bit track = 1'b1);
        req_t r;
        exp_t e;
        @(negedge clk);
        r = '{valid: 1'b1, write: wr, size: sz, uns: uns, addr: addr, wdata: wd};
        e = '{rdata: exp_d, fault: exp_f, cyc: cyc + (sel ? LAT_B : LAT_A)};
        if (sel) begin
            check("b_req_ready", {31'd0, ready_b}, 32'd1);
            req_b = r;
            if (track) q_b.push_back(e);
        end else begin
            check("a_req_ready", {31'd0, ready_a}, 32'd1);
            req_a = r;
            if (track) q_a.push_back(e);
            if (exp_f)   exp_faults++;
            else if (wr) exp_stores++;
            else         exp_loads++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_a.valid = 1'b0;
            req_b.valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("rst_ready_a", {31'd0, ready_a}, 32'd0);
        check("rst_valid_a", {31'd0, valid_a}, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_fault_a", {31'd0, fault_a}, 32'd0);
        check("rst_ready_b", {31'd0, ready_b}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        check("ready_before_edge", {31'd0, ready_a}, 32'd0);
        @(negedge clk);
        check("ready_after_edge", {31'd0, ready_a}, 32'd1);

        // Instance A, READ_LAT=1.
        issue(0, 0, SW, 0, 16'h0010, 32'h0,        32'h0000_0004, 0);
        issue(0, 1, SW, 0, 16'h0020, 32'h80FF7F01, 32'h0,         0);
        issue(0, 0, SW, 0, 16'h0020, 32'h0,        32'h80FF_7F01, 0);
        issue(0, 0, SB, 0, 16'h0021, 32'h0,        32'h0000_007F, 0);
        issue(0, 0, SB, 0, 16'h0022, 32'h0,        32'hFFFF_FFFF, 0);
        issue(0, 0, SH, 1, 16'h0022, 32'h0,        32'h0000_80FF, 0);
        issue(0, 0, SH, 0, 16'h0022, 32'h0,        32'hFFFF_80FF, 0);
        issue(0, 0, SB, 1, 16'h0023, 32'h0,        32'h0000_0080, 0);
        issue(0, 0, SB, 0, 16'h0023, 32'h0,        32'hFFFF_FF80, 0);
        issue(0, 0, SB, 0, 16'h0020, 32'h0,        32'h0000_0001, 0);
        issue(0, 1, SB, 0, 16'h0046, 32'hDEADBEAB, 32'h0,         0);
        issue(0, 0, SW, 0, 16'h0044, 32'h0,        32'h00AB_0011, 0);
        issue(0, 1, SH, 0, 16'h004A, 32'h1234C0DE, 32'h0,         0);
        issue(0, 0, SW, 0, 16'h0048, 32'h0,        32'hC0DE_0012, 0);
        issue(0, 0, SH, 1, 16'h0048, 32'h0,        32'h0000_0012, 0);
        issue(0, 0, SH, 0, 16'h004A, 32'h0,        32'hFFFF_C0DE, 0);
        issue(0, 0, SH, 0, 16'h0003, 32'h0,        32'h0,         1);
        issue(0, 0, SW, 0, 16'h0002, 32'h0,        32'h0,         1);
        issue(0, 1, SW, 0, 16'h0400, 32'hFFFFFFFF, 32'h0,         1);
        issue(0, 0, SW, 0, 16'h0000, 32'h0,        32'h0,         0);
        issue(0, 0, SW, 0, 16'h0400, 32'h0,        32'h0,         1);
        issue(0, 1, SX, 0, 16'h0050, 32'hFFFFFFFF, 32'h0,         1);
        issue(0, 0, SW, 0, 16'h0050, 32'h0,        32'h0000_0014, 0);
        issue(0, 0, SX, 0, 16'h0054, 32'h0,        32'h0,         1);
        issue(0, 1, SB, 0, 16'h0060, 32'h00000011, 32'h0,         0);
        issue(0, 1, SB, 0, 16'h0060, 32'h00000022, 32'h0,         0);
        issue(0, 0, SW, 0, 16'h0060, 32'h0,        32'h0000_0022, 0);
        issue(0, 1, SH, 0, 16'h0065, 32'h0000FFFF, 32'h0,         1);
        issue(0, 0, SW, 0, 16'h0064, 32'h0,        32'h0000_0019, 0);
        idle(1);

        // Instance B, READ_LAT=3: back-to-back loads, then reset mid-flight.
        issue(1, 0, SW, 0, 16'h0000, 32'h0,        32'h0,         0);
        issue(1, 0, SW, 0, 16'h0004, 32'h0,        32'h1,         0);
        issue(1, 0, SW, 0, 16'h0008, 32'h0,        32'h2,         0);
        idle(6);
        issue(1, 1, SW, 0, 16'h000C, 32'hCAFEF00D, 32'h0,         0);
        idle(6);
        issue(1, 0, SW, 0, 16'h000C, 32'h0,        32'h0,         0, 1'b0);
        idle(2);
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_rst_ready", {31'd0, ready_b}, 32'd0);
            check("b_rst_valid", {31'd0, valid_b}, 32'd0);
        end
        rst_b = 1'b0;
        @(negedge clk);
        check("b_ready_after_rst", {31'd0, ready_b}, 32'd1);
        issue(1, 0, SW, 0, 16'h000C, 32'h0,        32'hCAFE_F00D, 0);
        idle(1);

        for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        check("a_scoreboard_drained", q_a.size(), 32'd0);
        check("b_scoreboard_drained", q_b.size(), 32'd0);
`ifdef DMEM_STATS_EN
        check("a_stat_loads",  st_ld_a, exp_loads);
        check("a_stat_stores", st_st_a, exp_stores);
        check("a_stat_faults", st_ft_a, exp_faults);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_ls_pipe.md
Name: dmem_ls_pipe

Overview:
- Parametrised successor to the single-cycle word data memory used by the MIPS datapath.
- Byte-addressed load/store memory: byte, halfword and word accesses with sign or zero extension.
- Valid/ready request port; fixed, configurable read latency; response pipeline; fault reporting for misaligned or out-of-range accesses.
- Sits between the MEM stage and the on-chip RAM array.

Parameters:
- DATA_W, 32, data word width in bits; must be 32 (four byte lanes).
- ADDR_W, 16, byte-address width.
- DEPTH, 256, number of DATA_W words in the array.
- READ_LAT, 1, cycles from request acceptance to rsp_valid; legal range 1..4.
- INIT_INDEX, 1, when 1 word i is initialised to i at time zero; when 0 it is initialised to 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (the byte or half sits in the low bits).
- rsp_valid  out  1  response pulse, one per accepted request.
- rsp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and faults.
- rsp_fault  out  1  the accepted request faulted.

Behaviour:
- Reset values:
  - While rst is high: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, all pipeline valid bits cleared.
  - From the first clk edge after rst deasserts: req_ready=1.
  - req_ready stays 1 thereafter; the block is fully pipelined and accepts one request per cycle.
- Acceptance: a request is accepted on the edge where req_valid and req_ready are both 1.
- Latency:
  - The response for every accepted request (load, store or fault) appears with rsp_valid=1 for exactly one cycle, READ_LAT cycles after acceptance.
  - Responses return in order. There is no response backpressure.
- Address split and endianness:
  - Word index = req_addr[ADDR_W-1:2]; byte lane = req_addr[1:0].
  - Little-endian: lane 0 is bits [7:0].
- Fault conditions (checked at acceptance):
  - req_size=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - word index >= DEPTH.
  - A faulted store does not modify the array. A faulted load returns rsp_rdata=0. Both return rsp_fault=1.
- Stores:
  - Committed to the array on the acceptance edge.
  - Only the addressed lanes are written: one lane for byte, lanes {addr[1],0} and {addr[1],1} for half, all four for word.
  - Unaddressed lanes are preserved.
- Loads:
  - Array data is sampled on the acceptance edge and carried through READ_LAT-1 further pipeline stages.
  - Lane extraction and extension are applied before the final stage.
  - Sign extension copies bit 7 (byte) or bit 15 (half).
- Read-after-write: a load accepted the cycle after a store to the same word returns the post-store data. Back-to-back same-word stores apply in acceptance order.
- Reset mid-operation: in-flight responses are discarded with no rsp_valid. Array contents are not cleared by rst.
- Array initialisation is performed only at time zero, as defined by INIT_INDEX.

Optional Feature:
- Macro DMEM_STATS_EN. When defined, three output ports are added:
  - stat_loads (32 bits): counts accepted non-faulting loads.
  - stat_stores (32 bits): counts accepted non-faulting stores.
  - stat_faults (32 bits): counts accepted faulting requests.
  - Each counter updates on the acceptance edge, saturates at all-ones and is cleared by rst.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the lane write-enable function (size, addr[1:0] -> 4-bit mask);
  - the load extraction/extension function.
- Sub-module dmem_rsp_pipe: a READ_LAT-deep shift pipeline of {valid, fault, rdata} with asynchronous clear of the valid bits on rst.

Test Plan:
- Reset then idle, INIT_INDEX=1, READ_LAT=1: word load at 0x0010 -> one cycle later rsp_valid=1, rsp_rdata=0x00000004, rsp_fault=0.
- Sign/zero extension:
  - Store word 0x80FF7F01 at 0x0020.
  - Byte load signed at 0x0021 -> 0x0000007F.
  - Byte load signed at 0x0022 -> 0xFFFFFFFF.
  - Half load unsigned at 0x0022 -> 0x000080FF.
  - Half load signed at 0x0022 -> 0xFFFF80FF.
- Partial store: word 0x44 holds 0x11; byte store 0xAB at 0x0046 -> word load at 0x0044 returns 0x00AB0011.
- Faults:
  - Half load at 0x0003 -> rsp_fault=1, rdata=0.
  - Word store at 0x0400 (index 256, DEPTH=256) -> fault=1, and a subsequent load confirms no array change.
  - req_size=11 -> fault=1.
- READ_LAT=3, back-to-back: loads at 0x00, 0x04, 0x08 on consecutive cycles -> responses 0, 1, 2 on consecutive cycles, starting 3 cycles after the first acceptance.
- Reset mid-flight, READ_LAT=3: assert rst one cycle after acceptance -> no rsp_valid; req_ready=0 during reset; a store committed before reset persists afterwards.
